// File: rtl/layer2_scheduler.sv
// Layer-2 sequencer: walks the (hidden j, output i) MAC loop into the gSRAM accumulators,
// then runs each accumulator through the sigmoid and writes it to the activation slot.
module layer2_scheduler #(
  parameter int N_HID   = 10,
  parameter int N_OUT   = 10,
  parameter int SIG_LAT = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] hid_addr_o,
  output logic [3:0] w2_addr_o,
  output logic       w2_next_o,
  output logic [3:0] g_row_o,
  output logic [3:0] g_col_o,
  output logic       g_we_o,
  output logic       g_mux_o,
  output logic       g_rd_zero_o,
  output logic       lut_sel_o
);

  typedef enum logic [2:0] {IDLE, MAC, SIG_RD, SIG_WR, DONE} state_t;

  localparam logic [3:0] J_LAST = 4'(N_HID - 1);
  localparam logic [3:0] I_LAST = 4'(N_OUT - 1);
  localparam logic [1:0] W_LAST = 2'(SIG_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] j_q, j_d;
  logic [3:0] i_q, i_d;
  logic [1:0] w_q, w_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      j_q     <= '0;
      i_q     <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      i_q     <= i_d;
      w_q     <= w_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    i_d         = i_q;
    w_d         = w_q;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    hid_addr_o  = '0;
    w2_addr_o   = '0;
    w2_next_o   = 1'b0;
    g_row_o     = '0;
    g_col_o     = '0;
    g_we_o      = 1'b0;
    g_mux_o     = 1'b0;
    g_rd_zero_o = 1'b0;
    lut_sel_o   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = MAC;
          j_d     = '0;
          i_d     = '0;
        end
      end

      // Same-address read-modify-write each cycle; the first hidden term ignores stale rdata.
      MAC: begin
        busy_o      = 1'b1;
        hid_addr_o  = j_q;
        w2_addr_o   = i_q;
        g_row_o     = i_q;
        g_we_o      = 1'b1;
        g_rd_zero_o = (j_q == 4'd0);
        w2_next_o   = (i_q == I_LAST);
        if (i_q == I_LAST) begin
          i_d = '0;
          if (j_q == J_LAST) begin
            state_d = SIG_RD;
            w_d     = '0;
          end else begin
            j_d = j_q + 4'd1;
          end
        end else begin
          i_d = i_q + 4'd1;
        end
      end

      SIG_RD: begin
        busy_o  = 1'b1;
        g_row_o = i_q;
        if (w_q == W_LAST) state_d = SIG_WR;
        else               w_d     = w_q + 2'd1;
      end

      SIG_WR: begin
        busy_o  = 1'b1;
        g_row_o = i_q;
        g_col_o = 4'd1;
        g_we_o  = 1'b1;
        g_mux_o = 1'b1;
        if (i_q == I_LAST) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 4'd1;
          w_d     = '0;
          state_d = SIG_RD;
        end
      end

      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/layer2_scheduler.md
# layer2_scheduler

Sequencer for the layer-2 stage of the two-layer network datapath. After layer 1 has produced its column of hidden activations, it drives the layer-2 multiply-accumulate loop over the hidden values and output neurons. It then passes every accumulated output through the sigmoid LUT and writes the results back into the answer SRAM. The datapath it steers is: hidden-value route registers, weight-2 row buffer, answer SRAM (gSRAM) and sigmoid.

## Interface
- N_HID, 10, number of hidden values consumed per pass (1..16)
- N_OUT, 10, number of output neurons (1..16)
- SIG_LAT, 1, sigmoid latency in cycles from sig_in to registered sig_out (1..4)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- start  in  1  layer-1 column valid; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse in the DONE state
- hid_addr  out  4  route-register address selecting the hidden value j fed to M2
- w2_addr  out  4  weight index i within the current weight-2 row
- w2_next  out  1  one-cycle pulse: advance weight-2 buffer to next row
- g_row  out  4  gSRAM row address (output neuron i)
- g_col  out  4  gSRAM column: 0 = accumulator slot, 1 = activation slot
- g_we  out  1  gSRAM write enable, write at clock edge
- g_mux  out  1  gSRAM write data select: 0 = m2result, 1 = sigmoid output
- g_rd_zero  out  1  forces the accumulator addend (rdata) to 0 for the first hidden term
- lut_sel  out  1  sigmoid input select: 0 = gSRAM rdata, 1 = route feedback

## Operation
- States: IDLE, MAC, SIG_RD, SIG_WR, DONE. Counters: j (hidden, 4b), i (output, 4b), w (wait, 2b).
- IDLE: all outputs 0. On start=1, j=i=0 and the block goes to MAC.
- MAC: one cycle per (j,i) pair, with i inner and j outer. Outputs in MAC:
  - hid_addr=j, w2_addr=i, g_row=i, g_col=0, g_we=1, g_mux=0, lut_sel=0
  - g_rd_zero=(j==0)
  - w2_next=1 when i==N_OUT-1, which gives N_HID pulses total, including on the last row.
- After (N_HID-1, N_OUT-1), the block goes to SIG_RD with i=0.
- SIG_RD: g_row=i, g_col=0, g_we=0, lut_sel=0. Held for SIG_LAT cycles (counter w), then SIG_WR.
- SIG_WR: g_row=i, g_col=1, g_we=1, g_mux=1. Then:
  - if i<N_OUT-1: i+1 and back to SIG_RD;
  - otherwise: DONE.
- DONE: done=1, busy=1, g_we=0. Returns to IDLE on the next cycle.
- Arithmetic belongs to the datapath (Q8.8 product bits [23:8] plus rdata). The scheduler only guarantees exactly one write per accumulator slot per hidden term, and that the first term is not summed with stale SRAM contents.
- start outside IDLE is ignored, not queued. That includes start asserted during DONE.

## Timing
- Reset values: every output 0, state IDLE, counters 0. Reset takes priority over start in the same cycle.
- Reset mid-operation: at the reset edge the block goes to IDLE, and g_we is 0 from the next cycle. Partially accumulated gSRAM contents are left as-is. The next start fully reinitializes via g_rd_zero.
- Cycle numbering: start is sampled at edge 0, and cycle 1 is the first MAC cycle.
- Cycle counts:
  - MAC occupies cycles 1..N_HID·N_OUT.
  - SIG occupies N_OUT·(SIG_LAT+1) cycles.
  - DONE is the final cycle.
  - Total latency to done is N_HID·N_OUT + N_OUT·(SIG_LAT+1) + 1 cycles; the defaults give 121.
- gSRAM read is combinational, so each MAC cycle is a same-address read-modify-write committed at the cycle's closing edge.
- Sigmoid data written in SIG_WR is the registered sig_out captured during SIG_RD. The address changes only after the write edge.
- Back-to-back: a new start is accepted in the first IDLE cycle after DONE.

## Test plan
- Defaults, single start with all hidden=1.0 (0x0100) and all weights=1.0:
  - accumulator slots read 0x0A00;
  - col 1 holds sigmoid(0x0A00);
  - done asserts in cycle 121;
  - busy is high for cycles 1..121.
- Two consecutive starts with different hidden data and dirty gSRAM: the second result is independent of the first, and g_rd_zero=1 exactly in cycles 1..10 of each pass.
- N_HID=1, N_OUT=1, SIG_LAT=3: MAC 1 cycle with g_rd_zero and w2_next both high; SIG_RD 3 cycles, SIG_WR 1 cycle; done in cycle 6.
- Reset asserted in MAC cycle 37:
  - outputs are 0 from cycle 38;
  - no writes afterwards;
  - a subsequent start produces the correct full result.
- start held high continuously: the pass repeats with one IDLE cycle between DONE and the next MAC cycle 1, and there is no start acceptance while busy.
- Count check over a default pass: exactly 100 MAC writes, 10 activation writes, and 10 w2_next pulses. hid_addr sequences 0..9, each value held for 10 consecutive cycles.
